// File: rtl/inst_ram_loader_pkg.sv
// Shared constants and state encoding for the instruction RAM loader.
package inst_ram_loader_pkg;

  localparam int unsigned AddrWDefault = 5;
  localparam logic [31:0] Nop          = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/inst_ram_loader_store.sv
// Instruction register file: one synchronous write port, one combinational read port,
// whole array cleared by the asynchronous reset.
module inst_ram_loader_store
  import inst_ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= Nop;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_ram_loader.sv
// Byte-stream loader for the CPU instruction store: packs bytes big-endian into words,
// holds the CPU during a load and serves combinational instruction fetches.
module inst_ram_loader
  import inst_ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = AddrWDefault,
  parameter int unsigned LOAD_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst,
  output logic        cpu_hold,
  output logic        load_done,
  output logic [5:0]  word_cnt
);

  state_e      state_q, state_d;
  logic [5:0]  word_cnt_q, word_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] asm_q, asm_d;
  logic        we;
  logic [31:0] rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    we         = 1'b0;
    in_ready   = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          word_cnt_d = '0;
          byte_idx_d = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        // A restart wins over a concurrent byte, which is dropped.
        if (load_start) begin
          word_cnt_d = '0;
          byte_idx_d = '0;
          asm_d      = '0;
        end else if (in_valid) begin
          asm_d      = {asm_q[15:0], in_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we         = 1'b1;
            word_cnt_d = word_cnt_q + 6'd1;
            if (word_cnt_d == 6'(LOAD_WORDS)) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        cpu_hold  = 1'b1;
        load_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  inst_ram_loader_store #(
    .ADDR_W(ADDR_W)
  ) u_store (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(word_cnt_q[ADDR_W-1:0]),
    .wdata({asm_q, in_data}),
    .raddr(inst_addr[ADDR_W+1:2]),
    .rdata(rdata)
  );

  // Only the word-index bits of the fetch address select a word.
  logic unused_addr;
  assign unused_addr = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0]};

  assign inst     = cpu_hold ? Nop : rdata;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Scoreboard bench for inst_ram_loader with a two-word load image.
module tb_inst_ram_loader;

  localparam int unsigned AddrW     = 5;
  localparam int unsigned LoadWords = 2;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        cpu_hold;
  logic        load_done;
  logic [5:0]  word_cnt;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          n_checks;
  int          n_errors;
  int          done_cnt;

  inst_ram_loader #(
    .ADDR_W    (AddrW),
    .LOAD_WORDS(LoadWords)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_start(load_start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .inst_addr (inst_addr),
    .inst      (inst),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    inst_addr = addr;
    #1;
    check(tag, inst, exp);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    next_cycle();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        next_cycle();
        check("hold_gap", {31'b0, cpu_hold}, 32'd1);
        check("nop_gap", inst, 32'h0);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      next_cycle();
      n++;
    end
    if (!in_ready) check("ready_timeout", {31'b0, in_ready}, 32'd1);
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic send_image(input logic [31:0] w0, input logic [31:0] w1, input bit gaps);
    logic [31:0] w;
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? w0 : w1;
      for (int j = 3; j >= 0; j--) begin
        send_byte(w[j*8 +: 8], gaps);
      end
      sb_q.push_back('{addr: 32'(i * 4), data: w});
    end
  endtask

  // Right after the last byte: DONE cycle, then back in IDLE.
  task automatic check_done(input string tag);
    check({tag, "_done"}, {31'b0, load_done}, 32'd1);
    check({tag, "_cnt"}, {26'b0, word_cnt}, 32'd2);
    check({tag, "_hold_done"}, {31'b0, cpu_hold}, 32'd1);
    next_cycle();
    check({tag, "_done_gone"}, {31'b0, load_done}, 32'd0);
    check({tag, "_hold_rel"}, {31'b0, cpu_hold}, 32'd0);
  endtask

  task automatic drain_sb(input string tag);
    sb_entry_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      read_check(tag, e.addr, e.data);
    end
  endtask

  initial begin
    int d0;
    n_checks   = 0;
    n_errors   = 0;
    done_cnt   = 0;
    rst_n      = 1'b0;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    inst_addr  = 32'h0;
    #12;
    rst_n = 1'b1;
    next_cycle();

    // Reset state
    read_check("rst_w0", 32'h0, 32'h0);
    read_check("rst_w31", 32'h7C, 32'h0);
    check("rst_hold", {31'b0, cpu_hold}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_cnt", {26'b0, word_cnt}, 32'd0);

    // Back-to-back load
    pulse_start();
    check("load_ready", {31'b0, in_ready}, 32'd1);
    check("load_hold", {31'b0, cpu_hold}, 32'd1);
    inst_addr = 32'h0;
    send_image(32'h3c010001, 32'h3c020002, 1'b0);
    check_done("b2b");
    drain_sb("b2b_sb");
    read_check("b2b_w2_unwritten", 32'h8, 32'h0);

    // Same image, random in_valid gaps
    d0 = done_cnt;
    pulse_start();
    send_image(32'h3c010001, 32'h3c020002, 1'b1);
    check_done("gap");
    drain_sb("gap_sb");
    check("gap_done_once", 32'(done_cnt - d0), 32'd1);

    // Restart mid-load: partial aa bb discarded, concurrent cc dropped
    d0 = done_cnt;
    pulse_start();
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b0);
    in_valid   = 1'b1;
    in_data    = 8'hcc;
    pulse_start();
    in_valid   = 1'b0;
    check("rst_cnt_restart", {26'b0, word_cnt}, 32'd0);
    send_image(32'h11223344, 32'h55667788, 1'b0);
    check_done("restart");
    drain_sb("restart_sb");
    check("restart_done_once", 32'(done_cnt - d0), 32'd1);

    // Async reset after 5 bytes
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h90 + i), 1'b0);
    rst_n = 1'b0;
    #2;
    read_check("arst_w0", 32'h0, 32'h0);
    read_check("arst_w1", 32'h4, 32'h0);
    check("arst_ready", {31'b0, in_ready}, 32'd0);
    check("arst_hold", {31'b0, cpu_hold}, 32'd0);
    check("arst_cnt", {26'b0, word_cnt}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    check("arst_no_done", 32'(done_cnt - d0), 32'd0);
    pulse_start();
    send_image(32'hdeadbeef, 32'h01234567, 1'b0);
    check_done("post_rst");
    drain_sb("post_rst_sb");

    // load_start with in_valid in IDLE: byte ee not accepted
    in_valid   = 1'b1;
    in_data    = 8'hee;
    pulse_start();
    in_valid   = 1'b0;
    check("idle_start_cnt", {26'b0, word_cnt}, 32'd0);
    send_image(32'hcafef00d, 32'h0badc0de, 1'b0);
    check_done("idle_start");
    drain_sb("idle_start_sb");
    read_check("alias_80", 32'h80, 32'hcafef00d);
    read_check("alias_hi", 32'hFFFF_FF87, 32'h0badc0de);
    read_check("w2_never", 32'h8, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
